// File: rtl/dma_wr_arb.sv
// dma_wr_arb: N-channel burst arbiter onto one DMA write port; DMA_ARB_RR_EN selects round-robin, else fixed priority.
// Latency: dma_wareq 1 clk after grant; beats pass combinationally from the granted lane; ch_done 1 clk after DMA idle.
// Backpressure: a beat moves only when dma_wvalid and ch_wvalid[g] are both high; either low stalls, source holds data.
module dma_wr_arb #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 16,
    localparam int GW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_50M,
    input  logic                     dma_rst,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*SIZE_W-1:0]   ch_size,
    input  logic [N_CH*DATA_W-1:0]   ch_wdata,
    input  logic [N_CH-1:0]          ch_wvalid,
    output logic [N_CH-1:0]          ch_wready,
    output logic [N_CH-1:0]          ch_done,
    output logic [N_CH-1:0]          ch_err,
    output logic [ADDR_W-1:0]        dma_waddr,
    output logic [SIZE_W-1:0]        dma_wsize,
    output logic                     dma_wareq,
    input  logic                     dma_wbusy,
    output logic [DATA_W-1:0]        dma_wdata,
    input  logic                     dma_wvalid,
    output logic                     dma_wready,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
    } desc_t;

    localparam logic [N_CH-1:0] ONE_HOT = N_CH'(1);

    state_t             state_q, state_d;
    logic [SIZE_W-1:0]  cnt_q;
    logic [GW-1:0]      gnt_q;
    desc_t              desc_lane  [N_CH];
    logic [DATA_W-1:0]  wdata_lane [N_CH];
    desc_t              sel_desc;
    logic               arb_vld;
    logic [GW-1:0]      arb_idx;
    logic               size_zero;
    logic               in_data;
    logic               beat;
    logic               last_beat;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        assign desc_lane[i].addr = ch_addr[i*ADDR_W +: ADDR_W];
        assign desc_lane[i].size = ch_size[i*SIZE_W +: SIZE_W];
        assign wdata_lane[i]     = ch_wdata[i*DATA_W +: DATA_W];
    end

`ifdef DMA_ARB_RR_EN
    logic [GW-1:0] ptr_q;
    int            rr_idx;

    // Scan candidates from the highest rotation offset down so the nearest one to ptr_q wins.
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        rr_idx  = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            rr_idx = int'(ptr_q) + k;
            if (rr_idx >= N_CH) rr_idx = rr_idx - N_CH;
            if (ch_req[rr_idx]) begin
                arb_vld = 1'b1;
                arb_idx = GW'(rr_idx);
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (dma_rst) begin
            ptr_q <= '0;
        end else if (state_q == IDLE && arb_vld) begin
            ptr_q <= (arb_idx == GW'(N_CH - 1)) ? '0 : arb_idx + GW'(1);
        end
    end
`else
    always_comb begin
        arb_vld = 1'b0;
        arb_idx = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ch_req[k]) begin
                arb_vld = 1'b1;
                arb_idx = GW'(k);
            end
        end
    end
`endif

    assign sel_desc  = desc_lane[arb_idx];
    assign size_zero = (sel_desc.size == '0);

    assign in_data    = (state_q == DATA);
    assign dma_wareq  = (state_q == REQ);
    assign busy       = (state_q != IDLE);
    assign grant_id   = gnt_q;
    assign dma_wready = in_data & ch_wvalid[gnt_q];
    assign ch_wready  = (in_data & dma_wvalid) ? (ONE_HOT << gnt_q) : '0;
    assign dma_wdata  = in_data ? wdata_lane[gnt_q] : '0;
    assign beat       = dma_wvalid & dma_wready;
    assign last_beat  = (cnt_q == dma_wsize - SIZE_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_vld && !size_zero) state_d = REQ;
            REQ:     if (dma_wbusy)             state_d = DATA;
            DATA:    if (beat && last_beat)     state_d = DRAIN;
            DRAIN:   if (!dma_wbusy)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Zero-length requests are rejected without touching the registered burst fields.
    always_ff @(posedge clk_50M) begin
        if (dma_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gnt_q     <= '0;
            dma_waddr <= '0;
            dma_wsize <= '0;
            ch_done   <= '0;
            ch_err    <= '0;
        end else begin
            state_q <= state_d;
            ch_done <= '0;
            ch_err  <= '0;
            if (state_q == IDLE && arb_vld) begin
                if (size_zero) begin
                    ch_err <= ONE_HOT << arb_idx;
                end else begin
                    gnt_q     <= arb_idx;
                    dma_waddr <= sel_desc.addr;
                    dma_wsize <= sel_desc.size;
                end
            end
            if (beat) begin
                cnt_q <= last_beat ? '0 : cnt_q + SIZE_W'(1);
            end
            if (state_q == DRAIN && !dma_wbusy) begin
                ch_done <= ONE_HOT << gnt_q;
            end
        end
    end

endmodule

// File: tb/tb_dma_wr_arb.sv
// tb_dma_wr_arb: directed scenarios with randomized data and handshakes against a burst-level reference model.
// Inputs driven on the falling edge, outputs sampled 1 time unit later.
module tb_dma_wr_arb;

    logic          clk_50M = 1'b0;
    logic          dma_rst;
    logic [3:0]    ch_req;
    logic [127:0]  ch_addr;
    logic [63:0]   ch_size;
    logic [255:0]  ch_wdata;
    logic [3:0]    ch_wvalid;
    logic [3:0]    ch_wready;
    logic [3:0]    ch_done;
    logic [3:0]    ch_err;
    logic [31:0]   dma_waddr;
    logic [15:0]   dma_wsize;
    logic          dma_wareq;
    logic          dma_wbusy;
    logic [63:0]   dma_wdata;
    logic          dma_wvalid;
    logic          dma_wready;
    logic [1:0]    grant_id;
    logic          busy;

    int checks   = 0;
    int failures = 0;

`ifdef DMA_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic [31:0] addr_m [4];
    logic [15:0] size_m [4];
    logic [63:0] base_m [4];
    int          ptr_m;

    always #5 clk_50M = ~clk_50M;

    dma_wr_arb dut (
        .clk_50M(clk_50M), .dma_rst(dma_rst),
        .ch_req(ch_req), .ch_addr(ch_addr), .ch_size(ch_size),
        .ch_wdata(ch_wdata), .ch_wvalid(ch_wvalid), .ch_wready(ch_wready),
        .ch_done(ch_done), .ch_err(ch_err),
        .dma_waddr(dma_waddr), .dma_wsize(dma_wsize), .dma_wareq(dma_wareq),
        .dma_wbusy(dma_wbusy), .dma_wdata(dma_wdata), .dma_wvalid(dma_wvalid),
        .dma_wready(dma_wready), .grant_id(grant_id), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arbitration rule: first requester at or after the start index, wrapping.
    function automatic int pick(input logic [3:0] pend, input int ptr);
        int start;
        start = RR ? ptr : 0;
        for (int k = 0; k < 4; k++) begin
            if (pend[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [63:0] beat_val(input int ch, input int i);
        return base_m[ch] ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [15:0] size);
        ch_addr[ch*32 +: 32] = addr;
        ch_size[ch*16 +: 16] = size;
        addr_m[ch] = addr;
        size_m[ch] = size;
        base_m[ch] = {$urandom, $urandom};
        ch_req[ch] = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_wareq"}, dma_wareq, 0);
        chk({tag, "_wready"}, dma_wready, 0);
        chk({tag, "_chwready"}, ch_wready, 0);
        chk({tag, "_done"},  ch_done, 0);
        chk({tag, "_err"},   ch_err, 0);
        chk({tag, "_addr"},  dma_waddr, 0);
        chk({tag, "_size"},  dma_wsize, 0);
        chk({tag, "_wdata"}, dma_wdata, 0);
        chk({tag, "_gid"},   grant_id, 0);
    endtask

    // Entered and left on a falling edge; moves `stop` beats of channel ch.
    task automatic run_data(input int ch, input int stop, input bit rnd);
        int got;
        int cyc;
        bit dv;
        bit sv;
        got = 0;
        cyc = 0;
        while (got < stop && cyc < 4000) begin
            dv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            sv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            dma_wvalid = dv;
            ch_wvalid = '0;
            ch_wvalid[ch] = sv;
            ch_wdata[ch*64 +: 64] = beat_val(ch, got);
            #1;
            chk("dma_wready", dma_wready, sv);
            chk("ch_wready", ch_wready, dv ? (4'b0001 << ch) : 4'b0000);
            if (dv && sv) begin
                chk("beat_data", dma_wdata, beat_val(ch, got));
                got++;
            end
            @(negedge clk_50M);
            cyc++;
        end
        chk("beat_count", got, stop);
        dma_wvalid = 1'b0;
        ch_wvalid = '0;
    endtask

    // One full burst for the expected winner; rst_at>0 aborts with reset after that many beats.
    task automatic serve(input int exp_ch, input int delay, input bit rnd, input bit keep, input int rst_at);
        int n;
        n = 0;
        #1;
        while (dma_wareq !== 1'b1 && n < 64) begin
            @(negedge clk_50M);
            #1;
            n++;
        end
        chk("wareq_seen", dma_wareq, 1);
        chk("grant_id", grant_id, exp_ch);
        chk("busy_req", busy, 1);
        chk("waddr", dma_waddr, addr_m[exp_ch]);
        chk("wsize", dma_wsize, size_m[exp_ch]);
        ptr_m = (exp_ch + 1) % 4;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk_50M);
            #1;
            chk("wareq_hold", dma_wareq, 1);
        end
        @(negedge clk_50M);
        dma_wbusy = 1'b1;
        @(negedge clk_50M);
        #1;
        chk("wareq_drop", dma_wareq, 0);
        chk("busy_data", busy, 1);
        @(negedge clk_50M);
        if (rst_at > 0) begin
            run_data(exp_ch, rst_at, 1'b0);
            dma_wvalid = 1'b1;
            ch_wvalid[exp_ch] = 1'b1;
            dma_rst = 1'b1;
            @(negedge clk_50M);
            #1;
            check_idle("rst_mid");
            dma_rst = 1'b0;
            dma_wvalid = 1'b0;
            ch_wvalid = '0;
            dma_wbusy = 1'b0;
            ptr_m = 0;
            @(negedge clk_50M);
            #1;
            chk("rst_no_done", ch_done, 0);
            @(negedge clk_50M);
            return;
        end
        run_data(exp_ch, int'(size_m[exp_ch]), rnd);
        dma_wvalid = 1'b1;
        ch_wvalid[exp_ch] = 1'b1;
        #1;
        chk("drain_no_beat", dma_wready, 0);
        chk("drain_no_chwready", ch_wready, 0);
        chk("drain_no_done", ch_done, 0);
        dma_wvalid = 1'b0;
        ch_wvalid = '0;
        dma_wbusy = 1'b0;
        @(negedge clk_50M);
        #1;
        chk("done_pulse", ch_done, 4'b0001 << exp_ch);
        chk("busy_after", busy, 0);
        if (!keep) ch_req[exp_ch] = 1'b0;
        @(negedge clk_50M);
        #1;
        chk("done_once", ch_done, 0);
        @(negedge clk_50M);
    endtask

    initial begin
        int exp_ch;
        int n0;
        bit keep;

        dma_rst = 1'b1;
        ch_req = '0;
        ch_addr = '0;
        ch_size = '0;
        ch_wdata = '0;
        ch_wvalid = '0;
        dma_wbusy = 1'b0;
        dma_wvalid = 1'b0;
        ptr_m = 0;
        repeat (3) @(negedge clk_50M);
        dma_rst = 1'b0;
        @(negedge clk_50M);
        #1;
        check_idle("reset");
        @(negedge clk_50M);

        // Single channel, fixed handshakes; wareq must rise one clock after the request.
        set_req(0, 32'h0000_1000, 16'd4);
        @(negedge clk_50M);
        #1;
        chk("wareq_latency", dma_wareq, 1);
        @(negedge clk_50M);
        serve(0, 2, 1'b0, 1'b0, 0);

        // Two simultaneous requesters, then a second pair.
        set_req(1, 32'h0000_2000, 16'd2);
        set_req(2, 32'h0000_3000, 16'd2);
        for (int r = 0; r < 2; r++) begin
            exp_ch = pick(ch_req, ptr_m);
            serve(exp_ch, 1, 1'b0, 1'b0, 0);
        end
        set_req(1, 32'h0000_2100, 16'd2);
        set_req(0, 32'h0000_1100, 16'd3);
        for (int r = 0; r < 2; r++) begin
            exp_ch = pick(ch_req, ptr_m);
            serve(exp_ch, 0, 1'b0, 1'b0, 0);
        end

        // Zero-length request: one error pulse, no DMA activity.
        set_req(2, 32'h0000_3300, 16'd0);
        @(negedge clk_50M);
        #1;
        chk("err_pulse", ch_err, 4'b0100);
        chk("err_busy", busy, 0);
        chk("err_wareq", dma_wareq, 0);
        ch_req[2] = 1'b0;
        ptr_m = 3;
        @(negedge clk_50M);
        #1;
        chk("err_once", ch_err, 0);
        chk("err_busy2", busy, 0);
        chk("err_wareq2", dma_wareq, 0);
        @(negedge clk_50M);

        // ch0 keeps re-requesting for a while alongside ch3.
        set_req(0, 32'h0000_4000, 16'd2);
        set_req(3, 32'h0000_5000, 16'd2);
        n0 = 0;
        for (int r = 0; r < 6 && ch_req != 4'b0000; r++) begin
            exp_ch = pick(ch_req, ptr_m);
            keep = (exp_ch == 0 && n0 < 2);
            if (exp_ch == 0) n0++;
            serve(exp_ch, 0, 1'b0, keep, 0);
        end

        // Single-beat burst boundary.
        set_req(1, $urandom, 16'd1);
        serve(1, 0, 1'b0, 1'b0, 0);

        // Randomized stalls on both sides.
        set_req(2, $urandom, 16'd8);
        serve(2, 1, 1'b1, 1'b0, 0);
        set_req(0, $urandom, 16'd5);
        serve(0, 0, 1'b1, 1'b0, 0);

        // Reset during beat 3 of 8, then the still-held request completes.
        set_req(3, 32'h0000_6000, 16'd8);
        serve(3, 0, 1'b0, 1'b0, 3);
        serve(3, 1, 1'b1, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
